vga_reset_seq: RTL and testbench

Clock-domain reset sequencer that consumes the raw startup conditions (internal reset, clock-manager lock, external reset button) and generates the staged, glitch-free reset and output-enable that the VGA core and its pins use. It mirrors, in synthesizable logic, the global set/reset-then-tristate-release ordering of the simulation-only global reset model. Core logic leaves reset first; pixel/sync pin drivers are enabled only after a fixed settle delay.

---
 rtl/vga_reset_pkg.sv | 26 ++
 rtl/vga_reset_debounce.sv | 46 ++++
 rtl/vga_reset_seq.sv | 130 +++++++++++++
 tb/tb_vga_reset_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_reset_pkg.sv
// Shared types and default timing constants for the VGA reset sequencer.
package vga_reset_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int unsigned HOLD_CYCLES_DEF     = 100;
    localparam int unsigned OE_DELAY_DEF        = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/vga_reset_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle press pulse per stable low period.
// Only instantiated when VGA_RESET_SEQ_DEBOUNCE_EN is defined.
module vga_reset_debounce #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // level_q is the accepted button level (1 = released); it only follows the
    // synced input after STABLE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q <= btn_n_i;
            sync_q <= meta_q;
            if (sync_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = level_q && !sync_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_reset_seq.sv
// Staged reset / output-enable sequencer for the VGA core and its pin drivers.
// Define VGA_RESET_SEQ_DEBOUNCE_EN to let a debounced button press re-sequence.
module vga_reset_seq
    import vga_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned OE_DELAY        = OE_DELAY_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic locked_i,
    input  logic btn_rst_n_i,
    output logic rst_core_o,
    output logic oe_o,
    output logic ready_o
);

    localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, OE_DELAY, 1)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OE_LAST   = (OE_DELAY == 0) ? '0 : CNT_W'(OE_DELAY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_meta_q, lock_sync_q;
    logic             btn_press;
    logic             abort;
    logic             rst_core_q, oe_q, ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= locked_i;
            lock_sync_q <= lock_meta_q;
        end
    end

`ifdef VGA_RESET_SEQ_DEBOUNCE_EN
    vga_reset_debounce #(
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_n_i (btn_rst_n_i),
        .press_o (btn_press)
    );
`else
    logic unused_btn;
    assign unused_btn = btn_rst_n_i;
    assign btn_press  = 1'b0;
`endif

    // Lock loss and a press collapse into the same abort, so both at once is one event.
    assign abort = !lock_sync_q || btn_press;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = (OE_DELAY == 0) ? ST_RUN : ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == OE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            rst_core_q <= 1'b1;
            oe_q       <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_core_q <= !((state_d == ST_RELEASE) || (state_d == ST_RUN));
            oe_q       <= (state_d == ST_RUN);
            ready_q    <= (state_d == ST_RUN);
        end
    end

    assign rst_core_o = rst_core_q;
    assign oe_o       = oe_q;
    assign ready_o    = ready_q;

    a_oe_not_in_reset: assert property (@(posedge clk_i) !(oe_q && rst_core_q));

endmodule

// File: tb/tb_vga_reset_seq.sv
// Self-checking bench for vga_reset_seq against a run-length reference model.
module tb_vga_reset_seq;

    localparam int H   = 100;
    localparam int OE  = 4;
    localparam int DEB = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic locked_i = 1'b0;
    logic btn_rst_n_i = 1'b1;
    logic rst_core_o, oe_o, ready_o;

    int n_tests = 0;
    int n_fail  = 0;

    vga_reset_seq #(
        .HOLD_CYCLES     (H),
        .OE_DELAY        (OE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .locked_i    (locked_i),
        .btn_rst_n_i (btn_rst_n_i),
        .rst_core_o  (rst_core_o),
        .oe_o        (oe_o),
        .ready_o     (ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: outputs follow from how many consecutive edges the
    // synchronized lock has been seen high since the last abort.
    logic l1, l2, b1, b2;
    bit   first_done;
    int   run;
    bit   armed;
    int   lowrun, highrun;
    logic exp_rst, exp_oe;

    task automatic tick();
        logic s, sb;
        bit   press;
        @(posedge clk_i);
        if (rst_i) begin
            l1 = 0; l2 = 0; b1 = 1; b2 = 1;
            first_done = 0; run = 0;
            armed = 1; lowrun = 0; highrun = 0;
        end else begin
            s  = l2;
            sb = b2;
            press = 0;
`ifdef VGA_RESET_SEQ_DEBOUNCE_EN
            if (armed) begin
                if (!sb) begin
                    lowrun++;
                    if (lowrun == DEB) begin press = 1; armed = 0; lowrun = 0; end
                end else lowrun = 0;
            end else begin
                if (sb) begin
                    highrun++;
                    if (highrun == DEB) begin armed = 1; highrun = 0; end
                end else highrun = 0;
            end
`endif
            if (!first_done) first_done = 1;
            else if (!s || (press && run > 0)) run = 0;
            else run++;
            l2 = l1; l1 = locked_i;
            b2 = b1; b1 = btn_rst_n_i;
        end
        exp_rst = (run < H + 1);
        exp_oe  = (run >= H + 1 + OE);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_i = 1;
        repeat (cycles) tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        locked_i = 1;
        rst_i = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rst_core_o !== 1'b1 || oe_o !== 1'b0 || ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c=%0d got rst_core/oe/ready=%b%b%b want 100", i, rst_core_o, oe_o, ready_o);
            end
            n_tests++;
        end
        rst_i = 0;
    endtask

    task automatic test_startup();
        int fall_e = -1, oe_e = -1;
        for (int e = 0; e < H + OE + 20; e++) begin
            tick();
            if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                n_fail++;
                $display("FAIL startup e=%0d got %b%b%b want %b%b%b", e, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
            end
            n_tests++;
            if (fall_e < 0 && rst_core_o === 1'b0) fall_e = e;
            if (oe_e < 0 && oe_o === 1'b1) oe_e = e;
        end
        if (fall_e != H + 2) begin
            n_fail++; $display("FAIL startup_fall_edge got %0d want %0d", fall_e, H + 2);
        end
        n_tests++;
        if (oe_e != H + 2 + OE) begin
            n_fail++; $display("FAIL startup_oe_edge got %0d want %0d", oe_e, H + 2 + OE);
        end
        n_tests++;
    endtask

    task automatic test_late_lock();
        int fall_k = -1, oe_k = -1;
        locked_i = 0;
        do_reset(3);
        repeat (20) begin
            tick();
            if (rst_core_o !== 1'b1 || oe_o !== 1'b0) begin
                n_fail++; $display("FAIL late_lock_wait got rst_core=%b oe=%b want 1 0", rst_core_o, oe_o);
            end
            n_tests++;
        end
        locked_i = 1;
        for (int k = 0; k < H + OE + 10; k++) begin
            tick();
            if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                n_fail++;
                $display("FAIL late_lock k=%0d got %b%b%b want %b%b%b", k, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
            end
            n_tests++;
            if (fall_k < 0 && rst_core_o === 1'b0) fall_k = k;
            if (oe_k < 0 && oe_o === 1'b1) oe_k = k;
        end
        if (fall_k != H + 2 || oe_k != H + 2 + OE) begin
            n_fail++; $display("FAIL late_lock_edges got fall=%0d oe=%0d want %0d %0d", fall_k, oe_k, H + 2, H + 2 + OE);
        end
        n_tests++;
    endtask

    task automatic test_hold_abort();
        int oe_k = -1;
        locked_i = 1;
        do_reset(2);
        repeat (2 + 50) tick();
        locked_i = 0;
        repeat (10) begin
            tick();
            if (oe_o !== 1'b0 || rst_core_o !== exp_rst) begin
                n_fail++; $display("FAIL hold_abort_low got rst_core=%b oe=%b want %b 0", rst_core_o, oe_o, exp_rst);
            end
            n_tests++;
        end
        locked_i = 1;
        for (int k = 0; k < H + OE + 10; k++) begin
            tick();
            if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                n_fail++;
                $display("FAIL hold_abort k=%0d got %b%b%b want %b%b%b", k, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
            end
            n_tests++;
            if (oe_k < 0 && oe_o === 1'b1) oe_k = k;
        end
        if (oe_k != H + 2 + OE) begin
            n_fail++; $display("FAIL hold_abort_restart got oe edge %0d want %0d", oe_k, H + 2 + OE);
        end
        n_tests++;
    endtask

    task automatic test_run_glitch();
        int k;
        if (oe_o !== 1'b1) begin
            n_fail++; $display("FAIL run_glitch_pre got oe=%b want 1", oe_o);
        end
        n_tests++;
        locked_i = 0;
        tick();
        locked_i = 1;
        k = 1;
        while (rst_core_o !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        if (k != 3 || oe_o !== 1'b0 || ready_o !== 1'b0) begin
            n_fail++; $display("FAIL run_glitch_abort got edges=%0d oe=%b ready=%b want 3 0 0", k, oe_o, ready_o);
        end
        n_tests++;
        for (int j = 0; j < H + OE + 10; j++) begin
            tick();
            if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                n_fail++;
                $display("FAIL run_glitch_reseq j=%0d got %b%b%b want %b%b%b", j, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
            end
            n_tests++;
        end
    endtask

    task automatic test_button();
        int plen[2] = '{10, 20};
        for (int p = 0; p < 2; p++) begin
            btn_rst_n_i = 0;
            for (int c = 0; c < plen[p] + H + OE + 30; c++) begin
                if (c == plen[p]) btn_rst_n_i = 1;
                tick();
                if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                    n_fail++;
                    $display("FAIL button p=%0d c=%0d got %b%b%b want %b%b%b", plen[p], c, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
                end
                n_tests++;
            end
        end
`ifndef VGA_RESET_SEQ_DEBOUNCE_EN
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL button_ignored got ready=%b want 1", ready_o);
        end
        n_tests++;
`endif
    endtask

    task automatic test_rst_mid();
        locked_i = 1;
        do_reset(2);
        repeat (H + 3) tick();
        for (int pass = 0; pass < 2; pass++) begin
            rst_i = 1;
            tick();
            rst_i = 0;
            if (rst_core_o !== 1'b1 || oe_o !== 1'b0 || ready_o !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid pass=%0d got %b%b%b want 100", pass, rst_core_o, oe_o, ready_o);
            end
            n_tests++;
            repeat (H + OE + 8) begin
                tick();
                if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe) begin
                    n_fail++;
                    $display("FAIL rst_mid_reseq got %b%b%b want %b%b%b", rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
                end
                n_tests++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 6000; c++) begin
            if (locked_i) begin
                if ($urandom_range(0, 199) == 0) locked_i = 0;
            end else if ($urandom_range(0, 4) == 0) locked_i = 1;
            if (btn_rst_n_i) begin
                if ($urandom_range(0, 59) == 0) btn_rst_n_i = 0;
            end else if ($urandom_range(0, 19) == 0) btn_rst_n_i = 1;
            rst_i = ($urandom_range(0, 799) == 0);
            tick();
            if (rst_core_o !== exp_rst || oe_o !== exp_oe || ready_o !== exp_oe || (oe_o && rst_core_o)) begin
                n_fail++;
                $display("FAIL random c=%0d got %b%b%b want %b%b%b", c, rst_core_o, oe_o, ready_o, exp_rst, exp_oe, exp_oe);
            end
            n_tests++;
        end
        rst_i = 0;
        btn_rst_n_i = 1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_late_lock();
        test_hold_abort();
        test_run_glitch();
        test_button();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
